seq_alu_exec: RTL
=================

Name: seq_alu_exec

Overview:
- Multi-cycle execute unit that consumes the 4-bit Operation code produced by the ALU control decoder, together with operands SrcA/SrcB.
- Returns ALUResult and Zero over valid/ready handshakes on both sides.
- Shifts are iterative, 1 bit per cycle. All other ops complete in one cycle.
- Sits in the EX stage between the register-read/immediate mux and the writeback/branch logic.

Parameters:
DATA_WIDTH, 32, operand/result width
SHAMT_W, 5, shift-amount bits taken from SrcB[SHAMT_W-1:0]

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  request valid
in_ready  output  1  unit can accept request
Operation  input  4  ALU operation code
SrcA  input  DATA_WIDTH  operand A
SrcB  input  DATA_WIDTH  operand B / shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
ALUResult  output  DATA_WIDTH  result
Zero  output  1  ALUResult == 0
Illegal  output  1  Operation was a reserved code
busy  output  1  state != IDLE

Behaviour:
- Operation codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 SUB
  - 0100 SLL
  - 0101 SRL
  - 0111 SRA
  - 1100 SLT (signed, result 1/0)
  - 1000 CMP: result = SrcA-SrcB; Zero gives BEQ.
  - Every other code is reserved: result 0, Illegal=1.
- Arithmetic: ADD/SUB/CMP wrap modulo 2^DATA_WIDTH; no overflow flag.
- Shift amount = SrcB[SHAMT_W-1:0]; upper bits of SrcB are ignored.
- SRA replicates the sign bit; SRL and SLL fill with 0.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, ALUResult=0, Zero=1, Illegal=0, busy=0.
  - Shift count and accumulator are cleared.
  - Reset mid-shift or in DONE aborts the operation; no result is emitted.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on the edge with in_valid=1; Operation/SrcA/SrcB are sampled on that edge.
  - Non-shift op or reserved code: result is registered and the unit goes to DONE. out_valid is high the cycle after accept (latency 1).
  - Shift op with amount 0: result=SrcA, go to DONE (latency 1).
  - Shift op with amount n>0: acc=SrcA, cnt=n, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: acc shifts by 1 in the selected direction, cnt decrements.
  - When cnt reaches 1, the last shift is applied and the unit goes to DONE.
  - out_valid rises n cycles after the accept edge (latency n, max 2^SHAMT_W-1 = 31).
- DONE:
  - out_valid=1, in_ready=0.
  - ALUResult, Zero and Illegal are held stable while out_ready=0 (no change under backpressure).
  - Edge with out_ready=1: go to IDLE, out_valid falls.
  - ALUResult/Zero/Illegal keep their last value until the next result.
- No pipelining: one operation in flight. Throughput is at most one op per 2 cycles for single-cycle ops.
- in_valid while in_ready=0 is ignored. The requester must hold its request, and it is not latched.
- Zero and Illegal are registered together with ALUResult, never combinational from the inputs.
- Simultaneous in_valid and out_ready in DONE: the result handshake completes; the new request is not accepted until IDLE (next cycle).

Test Plan:
- Reset, then ADD SrcA=5, SrcB=7 with out_ready=1 -> out_valid 1 cycle after accept, ALUResult=12, Zero=0, then back to IDLE.
- SUB 0x10-0x10, then CMP 3 vs 4 -> first: ALUResult=0, Zero=1; second: ALUResult=0xFFFFFFFF, Zero=0.
- SRA SrcA=0x80000000, SrcB=4 -> busy for 4 cycles, in_ready=0 throughout, ALUResult=0xF8000000; SLL by 31 of 1 -> 0x80000000 after 31 cycles; SRL by 0 of 0xABCD -> 0xABCD after 1 cycle.
- SLT -1 vs 1 -> ALUResult=1; SLT 1 vs -1 -> 0; AND 0xF0F0 & 0xFF00 -> 0xF000; OR -> 0xFFF0.
- Reserved code 1111 -> Illegal=1, ALUResult=0, Zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_valid pulses ignored.
- Reset asserted mid-SRL by 20 at cycle 10 -> next cycle IDLE, out_valid=0, and no stale result appears.

Source files
------------

// File: rtl/seq_alu_exec.sv
// seq_alu_exec: multi-cycle EX-stage execute unit with valid/ready on both sides.
// Single-cycle logic/arith ops; shifts iterate one bit per cycle.
module seq_alu_exec #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  Illegal,
  output logic                  busy
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [SHAMT_W-1:0]    r_cnt;
  logic [3:0]            r_op;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_illegal;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;

  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_is_shift;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_acc_next;

  assign w_shamt    = SrcB[SHAMT_W-1:0];
  assign w_is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

  // Single-cycle result for the incoming request; shift by 0 passes SrcA through
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (Operation)
      OP_AND: w_result = SrcA & SrcB;
      OP_OR:  w_result = SrcA | SrcB;
      OP_ADD: w_result = SrcA + SrcB;
      OP_SUB: w_result = SrcA - SrcB;
      OP_CMP: w_result = SrcA - SrcB;
      OP_SLT: w_result = ($signed(SrcA) < $signed(SrcB)) ? DATA_WIDTH'(1) : '0;
      OP_SLL: w_result = SrcA;
      OP_SRL: w_result = SrcA;
      OP_SRA: w_result = SrcA;
      default: begin
        w_result  = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // One-bit shift step of the accumulator in the latched direction
  always_comb begin
    w_acc_next = r_acc;
    case (r_op)
      OP_SLL:  w_acc_next = {r_acc[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  w_acc_next = {1'b0, r_acc[DATA_WIDTH-1:1]};
      OP_SRA:  w_acc_next = {r_acc[DATA_WIDTH-1], r_acc[DATA_WIDTH-1:1]};
      default: w_acc_next = r_acc;
    endcase
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_op        <= OP_AND;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_illegal   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= Operation;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_is_shift && (w_shamt != '0)) begin
              r_acc   <= SrcA;
              r_cnt   <= w_shamt;
              r_state <= S_SHIFT;
            end else begin
              r_result    <= w_result;
              r_zero      <= (w_result == '0);
              r_illegal   <= w_illegal;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Result regs stay put until the consumer takes them
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign Illegal   = r_illegal;
  assign busy      = r_busy;

endmodule
